frame_capture_ctrl: RTL and testbench
=====================================

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 256000: pixels per stored frame (640x400 active area).
REQ-002 SHALL have parameter ADDR_W, default 18: BRAM address width; FRAME_PIXELS <= 2^ADDR_W.
REQ-003 SHALL have port clk  input  1: single system clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port capture_req  input  1: one-cycle request to capture the next full frame.
REQ-006 SHALL have port release_req  input  1: one-cycle request to return to live video.
REQ-007 SHALL have port vsync  input  1: active-low VGA vertical sync, already aligned with pixel_in.
REQ-008 SHALL have port in_display  input  1: high when the current pixel lies in the stored active area.
REQ-009 SHALL have port pixel_in  input  24: live RGB pixel, R[23:16], G[15:8], B[7:0].
REQ-010 SHALL have port bram_state  output  2: 00 BRAM_IDLE, 01 CAPTURE_FRAME, 10 WRITING_FRAME, 11 READING_FRAME.
REQ-011 SHALL have port bram_we  output  1: BRAM write enable.
REQ-012 SHALL have port bram_addr  output  ADDR_W: BRAM address for write or read.
REQ-013 SHALL have port bram_din  output  8: packed pixel {R[7:5],G[7:5],B[7:6]}.
REQ-014 SHALL have port frame_valid  output  1: high while a complete frame is held in BRAM.
REQ-015 SHALL have port busy  output  1: high in CAPTURE_FRAME or WRITING_FRAME.

Function
REQ-016 SHALL detect the frame start as a registered falling edge of vsync (vsync_q=1, vsync=0).
REQ-017 In BRAM_IDLE, capture_req SHALL move the state to CAPTURE_FRAME on the next cycle and clear frame_valid.
REQ-018 In CAPTURE_FRAME, a frame-start edge SHALL move the state to WRITING_FRAME and zero the write counter.
REQ-019 In WRITING_FRAME, each cycle with in_display=1 SHALL register bram_we=1, bram_addr=write counter and bram_din=packed pixel_in, then increment the counter; bram_we SHALL be 0 on all other cycles.
REQ-020 Write latency SHALL be exactly 1 cycle from pixel_in/in_display to bram_we/bram_addr/bram_din.
REQ-021 The write at counter FRAME_PIXELS-1 SHALL move the state to READING_FRAME on the next cycle, set frame_valid=1 and zero the read counter.
REQ-022 A frame-start edge in WRITING_FRAME before the final write SHALL zero the write counter and restart the capture; the state SHALL remain WRITING_FRAME.
REQ-023 In READING_FRAME, bram_we SHALL be 0, and each cycle with in_display=1 SHALL register bram_addr=read counter, then increment the counter.
REQ-024 The read counter SHALL wrap from FRAME_PIXELS-1 to 0 and SHALL be zeroed by every frame-start edge.
REQ-025 capture_req in READING_FRAME SHALL clear frame_valid and move the state to CAPTURE_FRAME (retake).
REQ-026 release_req in any state SHALL move the state to BRAM_IDLE, clear frame_valid, force bram_we=0 and hold bram_addr at 0.
REQ-027 If release_req and capture_req arrive in the same cycle, release_req SHALL win.
REQ-028 capture_req in CAPTURE_FRAME or WRITING_FRAME SHALL be ignored.
REQ-029 busy SHALL be a combinational decode of the registered state; all other outputs SHALL be registered.
REQ-030 Counters SHALL be ADDR_W bits wide and SHALL never exceed FRAME_PIXELS-1.

Reset
REQ-031 While reset_n=0, and asynchronously on its assertion: bram_state=00, bram_we=0, bram_addr=0, bram_din=0, frame_valid=0, busy=0, both counters 0, vsync_q=1.
REQ-032 Reset asserted mid-write SHALL abandon the frame; after release the block SHALL stay in BRAM_IDLE until a new capture_req.

Verification (FRAME_PIXELS=16, ADDR_W=5)
REQ-033 Capture: capture_req, vsync falling edge, 16 in_display cycles with pixel_in=24'hE0C080 -> 16 writes at addr 0..15 with bram_din=8'hFA, then bram_state=11, frame_valid=1.
REQ-034 Gaps: in_display toggles 1,0,1 -> bram_we pulses only on the high cycles, and addresses stay contiguous.
REQ-035 Early frame edge: vsync falls after 10 writes -> the next write is at addr 0, the state stays 10, and completion needs 16 further writes.
REQ-036 Read wrap: in READING_FRAME, 20 in_display cycles with no vsync edge -> addr 0..15, 0..3; then a vsync edge -> the next addr is 0.
REQ-037 Priority: capture_req and release_req in the same cycle during READING_FRAME -> state 00, frame_valid=0, bram_we=0.
REQ-038 Async reset: reset_n pulsed low mid-WRITING between clock edges -> outputs take their reset values immediately, and the state stays 00 afterwards.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl: freezes one full VGA frame into a BRAM and then replays it.
// The live pixel stream is packed to 8 bits (RGB 3:3:2) and written when a capture
// is armed and a frame starts; once the last pixel is stored, the block plays the frame
// back by supplying read addresses in step with in_display until release_req is seen.
//
// Ports:
//   clk, reset_n      - system clock, asynchronous active-low reset
//   capture_req       - one-cycle request to capture the next full frame
//   release_req       - one-cycle request to return to live video (highest priority)
//   vsync             - active-low vertical sync, aligned with pixel_in
//   in_display        - current pixel lies inside the stored active area
//   pixel_in[23:0]    - live RGB888 pixel
//   bram_state[1:0]   - 00 idle, 01 armed, 10 writing, 11 reading
//   bram_we           - BRAM write enable
//   bram_addr         - BRAM address for write or read
//   bram_din[7:0]     - packed pixel {R[7:5],G[7:5],B[7:6]}
//   frame_valid       - a complete frame is held in BRAM
//   busy              - combinational: armed or writing
module frame_capture_ctrl #(
  parameter int unsigned FRAME_PIXELS = 256000,
  parameter int unsigned ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              capture_req,
  input  logic              release_req,
  input  logic              vsync,
  input  logic              in_display,
  input  logic [23:0]       pixel_in,
  output logic [1:0]        bram_state,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              frame_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic [1:0] {
    BRAM_IDLE     = 2'b00,
    CAPTURE_FRAME = 2'b01,
    WRITING_FRAME = 2'b10,
    READING_FRAME = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              vsync_q;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        din_d;
  logic              valid_d;
  logic              frame_start;
  logic [7:0]        pix_packed;
  logic [ADDR_W-1:0] wr_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic              unused_pix;

  // Frame start: vsync seen high last cycle and low now.
  assign frame_start = vsync_q & ~vsync;
  assign pix_packed  = {pixel_in[23:21], pixel_in[15:13], pixel_in[7:6]};
  assign unused_pix  = ^{pixel_in[20:16], pixel_in[12:8], pixel_in[5:0]};

  // A frame-start edge restarts the counters before any same-cycle access.
  assign wr_idx = frame_start ? '0 : wr_cnt_q;
  assign rd_idx = frame_start ? '0 : rd_cnt_q;

  assign bram_state = state_q;
  assign busy       = (state_q == CAPTURE_FRAME) || (state_q == WRITING_FRAME);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BRAM_IDLE;
      vsync_q     <= 1'b1;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      frame_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      bram_we     <= we_d;
      bram_addr   <= addr_d;
      bram_din    <= din_d;
      frame_valid <= valid_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_idx;
    we_d     = 1'b0;
    addr_d   = bram_addr;
    din_d    = bram_din;
    valid_d  = frame_valid;

    if (release_req) begin
      state_d  = BRAM_IDLE;
      valid_d  = 1'b0;
      addr_d   = '0;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      unique case (state_q)
        BRAM_IDLE: begin
          if (capture_req) begin
            state_d = CAPTURE_FRAME;
            valid_d = 1'b0;
          end
        end
        CAPTURE_FRAME: begin
          if (frame_start) begin
            state_d  = WRITING_FRAME;
            wr_cnt_d = '0;
          end
        end
        WRITING_FRAME: begin
          wr_cnt_d = wr_idx;
          if (in_display) begin
            we_d   = 1'b1;
            addr_d = wr_idx;
            din_d  = pix_packed;
            if (wr_idx == LAST_IDX) begin
              state_d  = READING_FRAME;
              valid_d  = 1'b1;
              wr_cnt_d = '0;
              rd_cnt_d = '0;
            end else begin
              wr_cnt_d = wr_idx + ONE;
            end
          end
        end
        READING_FRAME: begin
          if (capture_req) begin
            state_d = CAPTURE_FRAME;
            valid_d = 1'b0;
          end else if (in_display) begin
            addr_d   = rd_idx;
            rd_cnt_d = (rd_idx == LAST_IDX) ? '0 : rd_idx + ONE;
          end
        end
        default: state_d = BRAM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl with a 16-pixel frame.
module tb_frame_capture_ctrl;

  localparam int unsigned FP = 16;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          capture_req, release_req, vsync, in_display;
  logic [23:0]   pixel_in;
  logic [1:0]    bram_state;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_din;
  logic          frame_valid;
  logic          busy;

  int tests = 0;
  int fails = 0;

  frame_capture_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .capture_req(capture_req),
    .release_req(release_req), .vsync(vsync), .in_display(in_display),
    .pixel_in(pixel_in), .bram_state(bram_state), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .frame_valid(frame_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(bram_state), 32'd0);
    chk({tag, "_we"},    32'(bram_we),    32'd0);
    chk({tag, "_addr"},  32'(bram_addr),  32'd0);
    chk({tag, "_din"},   32'(bram_din),   32'd0);
    chk({tag, "_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  // Arm a capture and issue a frame-start edge; leaves the DUT in WRITING_FRAME.
  task automatic arm_and_start(input string tag);
    capture_req = 1'b1; in_display = 1'b0;
    step();
    capture_req = 1'b0;
    chk({tag, "_armed"}, 32'(bram_state), 32'd1);
    chk({tag, "_armed_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_armed_busy"}, 32'(busy), 32'd1);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    chk({tag, "_writing"}, 32'(bram_state), 32'd2);
  endtask

  task automatic write_px(input string tag, input logic [23:0] px, input int exp_addr,
                          input logic [7:0] exp_din);
    in_display = 1'b1; pixel_in = px;
    step();
    in_display = 1'b0;
    chk({tag, "_we"},   32'(bram_we),   32'd1);
    chk({tag, "_addr"}, 32'(bram_addr), 32'(exp_addr));
    chk({tag, "_din"},  32'(bram_din),  32'(exp_din));
  endtask

  initial begin
    reset_n = 1'b0; capture_req = 1'b0; release_req = 1'b0;
    vsync = 1'b1; in_display = 1'b0; pixel_in = '0;
    #3;
    chk_reset_vals("por");
    reset_n = 1'b1;
    step();
    chk("idle_state", 32'(bram_state), 32'd0);

    // Full capture of 16 pixels E0C080 -> packed FA.
    arm_and_start("cap");
    for (int i = 0; i < 16; i++) begin
      write_px("cap_wr", 24'hE0C080, i, 8'hFA);
      if (i == 14) chk("cap_not_done", 32'(bram_state), 32'd2);
    end
    chk("cap_done_state", 32'(bram_state), 32'd3);
    chk("cap_done_valid", 32'(frame_valid), 32'd1);
    chk("cap_done_busy",  32'(busy), 32'd0);
    step();
    chk("cap_idle_we", 32'(bram_we), 32'd0);

    // Read: 20 display cycles wrap 0..15, 0..3; then a frame edge restarts at 0.
    for (int i = 0; i < 20; i++) begin
      in_display = 1'b1;
      step();
      chk("rd_we",   32'(bram_we),   32'd0);
      chk("rd_addr", 32'(bram_addr), 32'(i % 16));
    end
    in_display = 1'b0; vsync = 1'b0;
    step();
    vsync = 1'b1; in_display = 1'b1;
    step();
    in_display = 1'b0;
    chk("rd_vsync_addr", 32'(bram_addr), 32'd0);
    chk("rd_vsync_state", 32'(bram_state), 32'd3);

    // Retake with gaps (1,0,1) and an early frame edge after 10 writes.
    arm_and_start("retake");
    write_px("gap_wr0", 24'hA55AC3, 0, 8'hAB);
    in_display = 1'b0;
    step();
    chk("gap_we_low", 32'(bram_we), 32'd0);
    write_px("gap_wr1", 24'hA55AC3, 1, 8'hAB);
    for (int i = 2; i < 10; i++) write_px("early_wr", 24'hE0C080, i, 8'hFA);
    vsync = 1'b0; in_display = 1'b0;
    step();
    vsync = 1'b1;
    chk("early_edge_we", 32'(bram_we), 32'd0);
    chk("early_edge_state", 32'(bram_state), 32'd2);
    for (int i = 0; i < 16; i++) begin
      write_px("restart_wr", 24'h1F3F7F, i, 8'h05);
      if (i == 14) chk("restart_not_done", 32'(bram_state), 32'd2);
    end
    chk("restart_done_state", 32'(bram_state), 32'd3);
    chk("restart_done_valid", 32'(frame_valid), 32'd1);

    // Simultaneous capture and release: release wins.
    in_display = 1'b1; step();
    capture_req = 1'b1; release_req = 1'b1;
    step();
    capture_req = 1'b0; release_req = 1'b0; in_display = 1'b0;
    chk("prio_state", 32'(bram_state), 32'd0);
    chk("prio_valid", 32'(frame_valid), 32'd0);
    chk("prio_we",    32'(bram_we), 32'd0);
    chk("prio_addr",  32'(bram_addr), 32'd0);

    // Asynchronous reset in the middle of a write burst.
    arm_and_start("ar");
    write_px("ar_wr0", 24'hE0C080, 0, 8'hFA);
    write_px("ar_wr1", 24'hE0C080, 1, 8'hFA);
    in_display = 1'b1;
    step();
    chk("ar_pre_we", 32'(bram_we), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("ar_async");
    #2 reset_n = 1'b1;
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    for (int i = 0; i < 4; i++) step();
    in_display = 1'b0;
    chk("ar_after_state", 32'(bram_state), 32'd0);
    chk("ar_after_we",    32'(bram_we), 32'd0);
    chk("ar_after_valid", 32'(frame_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
